// File: rtl/alu_op_issuer_pkg.sv
// alu_op_issuer_pkg: shared types and widths for the ALU operand issuer
package alu_op_issuer_pkg;
   localparam int OP_W        = 4;
   localparam int MOVI_W      = 2;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_DELAY_W = 8;

   typedef enum logic [1:0] {IDLE, DELAY, DRIVE} issuer_state_t;

   typedef struct packed {
      logic [DEF_DELAY_W-1:0] delay;
      logic [OP_W-1:0]        op;
      logic [MOVI_W-1:0]      movi;
      logic [DEF_DATA_W-1:0]  a;
      logic [DEF_DATA_W-1:0]  b;
      logic [DEF_DATA_W-1:0]  mem;
      logic [DEF_DATA_W-1:0]  imm;
   } alu_stim_t;
endpackage

// File: rtl/alu_issuer_delay_cnt.sv
// alu_issuer_delay_cnt: loadable down-counter with zero/one flags for idle-delay insertion
module alu_issuer_delay_cnt #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   output logic         zero_o,
   output logic         one_o
);
   logic [W-1:0] cnt_q, cnt_d;

   // load takes priority; otherwise count down and rest at zero
   always_comb begin
      cnt_d = ld_i ? ld_val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
   end

   // counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == W'(1));
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: takes stimulus words, inserts idle delay, drives operands to the ALU and counts transfers
module alu_op_issuer
   import alu_op_issuer_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DELAY_WIDTH = 8,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   IN_VLD,
   output logic                   IN_RDY,
   input  logic [DELAY_WIDTH-1:0] IN_DELAY,
   input  logic [OP_W-1:0]        IN_OP,
   input  logic [MOVI_W-1:0]      IN_MOVI,
   input  logic [DATA_WIDTH-1:0]  IN_A,
   input  logic [DATA_WIDTH-1:0]  IN_B,
   input  logic [DATA_WIDTH-1:0]  IN_MEM,
   input  logic [DATA_WIDTH-1:0]  IN_IMM,
   input  logic [CNT_WIDTH-1:0]   LIMIT,
   output logic                   ACT,
   output logic [OP_W-1:0]        OP,
   output logic [MOVI_W-1:0]      MOVI,
   output logic [DATA_WIDTH-1:0]  REG_A,
   output logic [DATA_WIDTH-1:0]  REG_B,
   output logic [DATA_WIDTH-1:0]  MEM,
   output logic [DATA_WIDTH-1:0]  IMM,
   input  logic                   ALU_RDY,
   output logic [CNT_WIDTH-1:0]   TRANS_CNT,
   output logic                   DONE
);
   issuer_state_t         state_q, state_d;
   logic [OP_W-1:0]       op_q;
   logic [MOVI_W-1:0]     movi_q;
   logic [DATA_WIDTH-1:0] a_q, b_q, mem_q, imm_q;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  load, xfer, dly_zero, dly_one;

   assign xfer = (state_q == DRIVE) & ALU_RDY;
   assign load = IN_VLD & IN_RDY;

   alu_issuer_delay_cnt #(.W(DELAY_WIDTH)) u_dly (
      .clk_i    (CLK),
      .rst_i    (RST),
      .ld_i     (load),
      .ld_val_i (IN_DELAY),
      .zero_o   (dly_zero),
      .one_o    (dly_one)
   );

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state: a load (from IDLE or alongside a transfer) restarts the sequence
   always_comb begin
      state_d = load                                      ? (IN_DELAY != '0 ? DELAY : DRIVE) :
                (state_q == DELAY) & (dly_one | dly_zero) ? DRIVE :
                xfer                                      ? IDLE  : state_q;
   end

   // outputs: ready is held low while reset is asserted even though the state reads IDLE
   always_comb begin
      ACT    = (state_q == DRIVE);
      IN_RDY = ~RST & ~done_q & ((state_q == IDLE) | xfer);
   end

   // operand registers capture the whole word on load
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_q   <= '0;
         movi_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         mem_q  <= '0;
         imm_q  <= '0;
      end else if (load) begin
         op_q   <= IN_OP;
         movi_q <= IN_MOVI;
         a_q    <= IN_A;
         b_q    <= IN_B;
         mem_q  <= IN_MEM;
         imm_q  <= IN_IMM;
      end
   end

   // saturating transfer count; done follows the post-edge count so it rises right after the limiting transfer
   always_comb begin
      cnt_d  = (xfer & ~&cnt_q) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
      done_d = (LIMIT != '0) & (cnt_d >= LIMIT);
   end

   // transfer counter and done flag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign OP        = op_q;
   assign MOVI      = movi_q;
   assign REG_A     = a_q;
   assign REG_B     = b_q;
   assign MEM       = mem_q;
   assign IMM       = imm_q;
   assign TRANS_CNT = cnt_q;
   assign DONE      = done_q;
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed self-checking bench for alu_op_issuer
module tb_alu_op_issuer;
   import alu_op_issuer_pkg::*;

   logic        CLK = 1'b0, RST = 1'b1;
   logic        IN_VLD = 1'b0, IN_RDY;
   logic [7:0]  IN_DELAY = '0;
   logic [3:0]  IN_OP = '0;
   logic [1:0]  IN_MOVI = '0;
   logic [7:0]  IN_A = '0, IN_B = '0, IN_MEM = '0, IN_IMM = '0;
   logic [31:0] LIMIT = '0;
   logic        ACT, ALU_RDY = 1'b0, DONE;
   logic [3:0]  OP;
   logic [1:0]  MOVI;
   logic [7:0]  REG_A, REG_B, MEM, IMM;
   logic [31:0] TRANS_CNT;
   int          errors = 0, checks = 0;

   alu_op_issuer dut (
      .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .IN_DELAY(IN_DELAY),
      .IN_OP(IN_OP), .IN_MOVI(IN_MOVI), .IN_A(IN_A), .IN_B(IN_B), .IN_MEM(IN_MEM),
      .IN_IMM(IN_IMM), .LIMIT(LIMIT), .ACT(ACT), .OP(OP), .MOVI(MOVI), .REG_A(REG_A),
      .REG_B(REG_B), .MEM(MEM), .IMM(IMM), .ALU_RDY(ALU_RDY), .TRANS_CNT(TRANS_CNT), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic offer(input alu_stim_t s);
      IN_VLD   = 1'b1;
      IN_DELAY = s.delay;
      IN_OP    = s.op;
      IN_MOVI  = s.movi;
      IN_A     = s.a;
      IN_B     = s.b;
      IN_MEM   = s.mem;
      IN_IMM   = s.imm;
      #1;
   endtask

   initial begin
      #12;
      chk("rst_act", ACT, 0);
      chk("rst_inrdy", IN_RDY, 0);
      chk("rst_cnt", TRANS_CNT, 0);
      chk("rst_done", DONE, 0);
      chk("rst_rega", REG_A, 0);
      RST = 1'b0;
      // single word, delay 0
      ALU_RDY = 1'b1;
      offer('{delay:8'd0, op:4'd3, movi:2'd1, a:8'h12, b:8'h34, mem:8'h56, imm:8'h78});
      chk("t1_inrdy", IN_RDY, 1);
      step();
      IN_VLD = 1'b0;
      #1;
      chk("t1_act", ACT, 1);
      chk("t1_op", OP, 3);
      chk("t1_rega", REG_A, 8'h12);
      chk("t1_regb", REG_B, 8'h34);
      chk("t1_movi", MOVI, 1);
      chk("t1_imm", IMM, 8'h78);
      step();
      chk("t1_act_off", ACT, 0);
      chk("t1_cnt", TRANS_CNT, 1);
      // delay 3
      offer('{delay:8'd3, op:4'd5, movi:2'd0, a:8'h01, b:8'h02, mem:8'h03, imm:8'h04});
      step();
      IN_VLD = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t2_idle", ACT, 0);
         step();
      end
      chk("t2_act", ACT, 1);
      chk("t2_op", OP, 5);
      step();
      chk("t2_act_off", ACT, 0);
      chk("t2_cnt", TRANS_CNT, 2);
      // ALU stalls for 5 cycles
      ALU_RDY = 1'b0;
      offer('{delay:8'd0, op:4'd9, movi:2'd2, a:8'hAA, b:8'hBB, mem:8'hCC, imm:8'hDD});
      step();
      IN_VLD = 1'b0;
      IN_A = 8'h55;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_act", ACT, 1);
         chk("t3_rega", REG_A, 8'hAA);
         chk("t3_op", OP, 9);
         chk("t3_inrdy", IN_RDY, 0);
         step();
      end
      chk("t3_cnt_stall", TRANS_CNT, 2);
      ALU_RDY = 1'b1;
      #1;
      chk("t3_inrdy_xfer", IN_RDY, 1);
      step();
      chk("t3_act_off", ACT, 0);
      chk("t3_cnt", TRANS_CNT, 3);
      // four back-to-back words
      offer('{delay:8'd0, op:4'd1, movi:2'd0, a:8'd1, b:8'd0, mem:8'd0, imm:8'd0});
      step();
      for (int i = 1; i <= 4; i++) begin
         IN_A = 8'(i + 1);
         IN_VLD = (i < 4);
         #1;
         chk("t4_act", ACT, 1);
         chk("t4_rega", REG_A, 32'(i));
         chk("t4_inrdy", IN_RDY, 1);
         step();
      end
      chk("t4_act_off", ACT, 0);
      chk("t4_cnt", TRANS_CNT, 7);
      // limit reached after two more transfers
      LIMIT = 32'd9;
      offer('{delay:8'd0, op:4'd2, movi:2'd0, a:8'h10, b:8'h20, mem:8'h30, imm:8'h40});
      step();
      IN_VLD = 1'b0;
      step();
      chk("t5_done_a", DONE, 0);
      chk("t5_cnt_a", TRANS_CNT, 8);
      offer('{delay:8'd0, op:4'd4, movi:2'd0, a:8'h11, b:8'h21, mem:8'h31, imm:8'h41});
      step();
      IN_VLD = 1'b0;
      #1;
      chk("t5_act_b", ACT, 1);
      chk("t5_done_b", DONE, 0);
      step();
      chk("t5_done", DONE, 1);
      chk("t5_cnt_b", TRANS_CNT, 9);
      offer('{delay:8'd0, op:4'd6, movi:2'd3, a:8'h99, b:8'h98, mem:8'h97, imm:8'h96});
      chk("t5_inrdy_blk", IN_RDY, 0);
      step();
      step();
      chk("t5_act_blk", ACT, 0);
      chk("t5_cnt_blk", TRANS_CNT, 9);
      chk("t5_inrdy_held", IN_RDY, 0);
      LIMIT = 32'd10;
      step();
      chk("t5_done_low", DONE, 0);
      chk("t5_inrdy_reopen", IN_RDY, 1);
      step();
      IN_VLD = 1'b0;
      #1;
      chk("t5_act_c", ACT, 1);
      chk("t5_rega_c", REG_A, 8'h99);
      step();
      chk("t5_done_c", DONE, 1);
      chk("t5_cnt_c", TRANS_CNT, 10);
      LIMIT = 32'd0;
      step();
      chk("t5_unlimited", DONE, 0);
      // async reset while in DELAY with counter at 2
      offer('{delay:8'd4, op:4'd8, movi:2'd0, a:8'h44, b:8'h45, mem:8'h46, imm:8'h47});
      step();
      IN_VLD = 1'b0;
      step();
      step();
      #2;
      RST = 1'b1;
      #1;
      chk("t6_act", ACT, 0);
      chk("t6_cnt", TRANS_CNT, 0);
      chk("t6_inrdy", IN_RDY, 0);
      chk("t6_rega", REG_A, 0);
      #2;
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_dropped", ACT, 0);
      end
      chk("t6_cnt_after", TRANS_CNT, 0);
      offer('{delay:8'd0, op:4'd7, movi:2'd0, a:8'h21, b:8'h22, mem:8'h23, imm:8'h24});
      chk("t6_inrdy_idle", IN_RDY, 1);
      step();
      IN_VLD = 1'b0;
      #1;
      chk("t6_act_new", ACT, 1);
      chk("t6_op_new", OP, 7);
      chk("t6_rega_new", REG_A, 8'h21);
      step();
      chk("t6_act_off", ACT, 0);
      chk("t6_cnt_new", TRANS_CNT, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
